// File: rtl/eth_egress_mon_if.sv
// rtl/eth_egress_mon_if.sv - word stream and statistics bundle for the egress monitor
interface eth_egress_mon_if #(
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          in_data;
  logic                 in_sop;
  logic                 in_eop;
  logic [31:0]          out_data;
  logic                 out_valid;
  logic                 out_sop;
  logic                 out_eop;
  logic                 out_abort;
  logic                 err_flag;
  logic [1:0]           err_code;
  logic [CNT_WIDTH-1:0] pkt_cnt;
  logic [CNT_WIDTH-1:0] misroute_cnt;
  logic [CNT_WIDTH-1:0] err_cnt;
  logic [15:0]          last_len;
  logic [31:0]          last_csum;

  modport master (
    output in_data, in_sop, in_eop,
    input  out_data, out_valid, out_sop, out_eop, out_abort,
    input  err_flag, err_code, pkt_cnt, misroute_cnt, err_cnt,
    input  last_len, last_csum
  );

  modport slave (
    input  in_data, in_sop, in_eop,
    output out_data, out_valid, out_sop, out_eop, out_abort,
    output err_flag, err_code, pkt_cnt, misroute_cnt, err_cnt,
    output last_len, last_csum
  );
endinterface

// File: rtl/eth_egress_mon.sv
// rtl/eth_egress_mon.sv - egress framing checker, one-cycle retimer and packet statistics
module eth_egress_mon #(
  parameter logic [31:0] PORT_ADDR = 32'habcd,
  parameter int          MAX_WORDS = 64,
  parameter int          CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  eth_egress_mon_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  localparam logic [15:0]          MAX_LEN = 16'(MAX_WORDS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [31:0]          csum_q, csum_d;
  logic                 mis_q, mis_d;
  logic [31:0]          out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic                 out_abort_q, out_abort_d;
  logic                 err_flag_q, err_flag_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]          last_len_q, last_len_d;
  logic [31:0]          last_csum_q, last_csum_d;

  logic                 good;
  logic                 fin_mis;
  logic [15:0]          fin_len;
  logic [31:0]          fin_csum;
  logic                 err;
  logic                 addr_miss;

  assign addr_miss = (bus.in_data != PORT_ADDR);

  // Framing decisions, forwarding and statistics next-state for the current input word
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    csum_d      = csum_q;
    mis_d       = mis_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_abort_d = 1'b0;
    err_code_d  = err_code_q;
    err         = 1'b0;
    good        = 1'b0;
    fin_len     = len_q + 16'd1;
    fin_csum    = csum_q + bus.in_data;
    fin_mis     = mis_q;

    case (state_q)
      IDLE, DROP: begin
        if (bus.in_sop) begin
          // A sop while dropping is reported, but the abort already went out with the oversize word
          if (state_q == DROP) begin
            err        = 1'b1;
            err_code_d = 2'd1;
          end
          out_valid_d = 1'b1;
          out_sop_d   = 1'b1;
          out_eop_d   = bus.in_eop;
          out_data_d  = bus.in_data;
          len_d       = 16'd1;
          csum_d      = bus.in_data;
          mis_d       = addr_miss;
          if (bus.in_eop) begin
            good     = 1'b1;
            fin_len  = 16'd1;
            fin_csum = bus.in_data;
            fin_mis  = addr_miss;
            state_d  = IDLE;
          end else begin
            state_d = BODY;
          end
        end else if (bus.in_eop) begin
          if (state_q == IDLE) begin
            err        = 1'b1;
            err_code_d = 2'd2;
          end
          state_d = IDLE;
        end
      end
      BODY: begin
        if (bus.in_sop) begin
          err         = 1'b1;
          err_code_d  = 2'd1;
          out_valid_d = 1'b1;
          out_sop_d   = 1'b1;
          out_abort_d = 1'b1;
          out_eop_d   = bus.in_eop;
          out_data_d  = bus.in_data;
          len_d       = 16'd1;
          csum_d      = bus.in_data;
          mis_d       = addr_miss;
          if (bus.in_eop) begin
            good     = 1'b1;
            fin_len  = 16'd1;
            fin_csum = bus.in_data;
            fin_mis  = addr_miss;
            state_d  = IDLE;
          end
        end else if (len_q == MAX_LEN) begin
          err         = 1'b1;
          err_code_d  = 2'd3;
          out_abort_d = 1'b1;
          state_d     = bus.in_eop ? IDLE : DROP;
        end else if (bus.in_eop) begin
          out_valid_d = 1'b1;
          out_eop_d   = 1'b1;
          out_data_d  = bus.in_data;
          good        = 1'b1;
          len_d       = fin_len;
          csum_d      = fin_csum;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data;
          len_d       = fin_len;
          csum_d      = fin_csum;
        end
      end
      default: state_d = IDLE;
    endcase

    err_flag_d  = err;
    pkt_cnt_d   = (good && pkt_cnt_q != CNT_MAX) ? pkt_cnt_q + 1'b1 : pkt_cnt_q;
    mis_cnt_d   = (good && fin_mis && mis_cnt_q != CNT_MAX) ? mis_cnt_q + 1'b1 : mis_cnt_q;
    err_cnt_d   = (err && err_cnt_q != CNT_MAX) ? err_cnt_q + 1'b1 : err_cnt_q;
    last_len_d  = good ? fin_len : last_len_q;
    last_csum_d = good ? fin_csum : last_csum_q;
  end

  // State, working registers and all registered outputs; reset drops any packet in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      csum_q      <= '0;
      mis_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_abort_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_code_q  <= '0;
      pkt_cnt_q   <= '0;
      mis_cnt_q   <= '0;
      err_cnt_q   <= '0;
      last_len_q  <= '0;
      last_csum_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      mis_q       <= mis_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_abort_q <= out_abort_d;
      err_flag_q  <= err_flag_d;
      err_code_q  <= err_code_d;
      pkt_cnt_q   <= pkt_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      err_cnt_q   <= err_cnt_d;
      last_len_q  <= last_len_d;
      last_csum_q <= last_csum_d;
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sop      = out_sop_q;
  assign bus.out_eop      = out_eop_q;
  assign bus.out_abort    = out_abort_q;
  assign bus.err_flag     = err_flag_q;
  assign bus.err_code     = err_code_q;
  assign bus.pkt_cnt      = pkt_cnt_q;
  assign bus.misroute_cnt = mis_cnt_q;
  assign bus.err_cnt      = err_cnt_q;
  assign bus.last_len     = last_len_q;
  assign bus.last_csum    = last_csum_q;

endmodule

// File: tb/tb_eth_egress_mon.sv
// tb/tb_eth_egress_mon.sv - scoreboard bench for eth_egress_mon
module tb_eth_egress_mon;

  localparam int CW = 2;

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic        sop;
    logic        eop;
    logic        abort;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  exp_t       fwd_q[$];
  logic [1:0] err_q[$];

  eth_egress_mon_if #(.CNT_WIDTH(CW)) bus ();

  eth_egress_mon #(
    .PORT_ADDR(32'habcd),
    .MAX_WORDS(4),
    .CNT_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // cycle stamp used to check the one-cycle forwarding latency
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic exp_fwd(input logic [31:0] d, input logic s, input logic e, input logic ab);
    exp_t x;
    x.data = d; x.valid = 1'b1; x.sop = s; x.eop = e; x.abort = ab; x.due = cyc + 1;
    fwd_q.push_back(x);
  endtask

  task automatic exp_drop_abort();
    exp_t x;
    x.data = '0; x.valid = 1'b0; x.sop = 1'b0; x.eop = 1'b0; x.abort = 1'b1; x.due = cyc + 1;
    fwd_q.push_back(x);
  endtask

  task automatic drive(input logic [31:0] d, input logic s, input logic e);
    bus.in_data = d;
    bus.in_sop  = s;
    bus.in_eop  = e;
    @(posedge clk);
    #1;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_fwd_left"}, fwd_q.size(), 0);
    chk({name, "_err_left"}, err_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_out_data"},  bus.out_data, 0);
    chk({name, "_out_valid"}, {31'd0, bus.out_valid}, 0);
    chk({name, "_out_sop"},   {31'd0, bus.out_sop}, 0);
    chk({name, "_out_eop"},   {31'd0, bus.out_eop}, 0);
    chk({name, "_out_abort"}, {31'd0, bus.out_abort}, 0);
    chk({name, "_err_flag"},  {31'd0, bus.err_flag}, 0);
    chk({name, "_err_code"},  {30'd0, bus.err_code}, 0);
    chk({name, "_pkt_cnt"},   32'(bus.pkt_cnt), 0);
    chk({name, "_mis_cnt"},   32'(bus.misroute_cnt), 0);
    chk({name, "_err_cnt"},   32'(bus.err_cnt), 0);
    chk({name, "_last_len"},  {16'd0, bus.last_len}, 0);
    chk({name, "_last_csum"}, bus.last_csum, 0);
  endtask

  task automatic monitor();
    exp_t       e;
    logic [1:0] ec;
    forever begin
      @(negedge clk);
      if (bus.out_valid || bus.out_abort) begin
        n_vec++;
        if (fwd_q.size() == 0) begin
          n_bad++;
          $display("FAIL fwd_unexpected: got data=%h valid=%b abort=%b, required no output",
                   bus.out_data, bus.out_valid, bus.out_abort);
        end else begin
          e = fwd_q.pop_front();
          if (bus.out_valid !== e.valid || bus.out_abort !== e.abort || cyc != e.due ||
              (e.valid && (bus.out_data !== e.data || bus.out_sop !== e.sop || bus.out_eop !== e.eop))) begin
            n_bad++;
            $display("FAIL fwd_word: got data=%h v=%b sop=%b eop=%b ab=%b cyc=%0d required data=%h v=%b sop=%b eop=%b ab=%b cyc=%0d",
                     bus.out_data, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_abort, cyc,
                     e.data, e.valid, e.sop, e.eop, e.abort, e.due);
          end
        end
      end
      if (bus.err_flag) begin
        n_vec++;
        if (err_q.size() == 0) begin
          n_bad++;
          $display("FAIL err_unexpected: got code=%0d, required no error", bus.err_code);
        end else begin
          ec = err_q.pop_front();
          if (bus.err_code !== ec) begin
            n_bad++;
            $display("FAIL err_code_pulse: got %0d required %0d", bus.err_code, ec);
          end
        end
      end
    end
  endtask

  initial begin
    bus.in_data = '0;
    bus.in_sop  = 1'b0;
    bus.in_eop  = 1'b0;
    fork
      monitor();
    join_none

    // reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // 4-word packet, exactly MAX_WORDS long
    exp_fwd(32'habcd, 1, 0, 0); drive(32'habcd, 1, 0);
    exp_fwd(32'd1, 0, 0, 0);    drive(32'd1, 0, 0);
    exp_fwd(32'd2, 0, 0, 0);    drive(32'd2, 0, 0);
    exp_fwd(32'd3, 0, 1, 0);    drive(32'd3, 0, 1);
    chk("p4_pkt_cnt", 32'(bus.pkt_cnt), 1);
    chk("p4_mis_cnt", 32'(bus.misroute_cnt), 0);
    chk("p4_last_len", {16'd0, bus.last_len}, 4);
    chk("p4_last_csum", bus.last_csum, 32'habd3);
    drain("p4");

    // single-word misrouted packet
    do_reset();
    exp_fwd(32'hcdef, 1, 1, 0); drive(32'hcdef, 1, 1);
    chk("p1_pkt_cnt", 32'(bus.pkt_cnt), 1);
    chk("p1_mis_cnt", 32'(bus.misroute_cnt), 1);
    chk("p1_last_len", {16'd0, bus.last_len}, 1);
    chk("p1_last_csum", bus.last_csum, 32'hcdef);
    drain("p1");

    // sop inside a packet restarts it
    do_reset();
    exp_fwd(32'habcd, 1, 0, 0); drive(32'habcd, 1, 0);
    exp_fwd(32'd7, 0, 0, 0);    drive(32'd7, 0, 0);
    exp_fwd(32'd8, 0, 0, 0);    drive(32'd8, 0, 0);
    exp_fwd(32'habcd, 1, 0, 1); err_q.push_back(2'd1); drive(32'habcd, 1, 0);
    exp_fwd(32'd5, 0, 1, 0);    drive(32'd5, 0, 1);
    chk("sop_err_code", {30'd0, bus.err_code}, 1);
    chk("sop_err_cnt", 32'(bus.err_cnt), 1);
    chk("sop_pkt_cnt", 32'(bus.pkt_cnt), 1);
    chk("sop_last_len", {16'd0, bus.last_len}, 2);
    chk("sop_last_csum", bus.last_csum, 32'habd2);
    drain("sop");

    // oversize: fifth word dropped with abort, sixth (eop) discarded
    do_reset();
    exp_fwd(32'habcd, 1, 0, 0); drive(32'habcd, 1, 0);
    exp_fwd(32'h11, 0, 0, 0);   drive(32'h11, 0, 0);
    exp_fwd(32'h12, 0, 0, 0);   drive(32'h12, 0, 0);
    exp_fwd(32'h13, 0, 0, 0);   drive(32'h13, 0, 0);
    exp_drop_abort(); err_q.push_back(2'd3); drive(32'h14, 0, 0);
    drive(32'h15, 0, 1);
    chk("ovs_pkt_cnt", 32'(bus.pkt_cnt), 0);
    chk("ovs_err_cnt", 32'(bus.err_cnt), 1);
    chk("ovs_err_code", {30'd0, bus.err_code}, 3);
    chk("ovs_last_len", {16'd0, bus.last_len}, 0);
    exp_fwd(32'habcd, 1, 1, 0); drive(32'habcd, 1, 1);
    chk("ovs_after_pkt_cnt", 32'(bus.pkt_cnt), 1);
    drain("ovs");

    // orphan eop in IDLE
    do_reset();
    err_q.push_back(2'd2); drive(32'h99, 0, 1);
    chk("orph_err_code", {30'd0, bus.err_code}, 2);
    chk("orph_err_cnt", 32'(bus.err_cnt), 1);
    chk("orph_out_valid", {31'd0, bus.out_valid}, 0);
    drive(32'h0, 0, 0);
    chk("orph_code_held", {30'd0, bus.err_code}, 2);
    chk("orph_flag_pulse", {31'd0, bus.err_flag}, 0);
    drain("orph");

    // reset mid-packet, then counter saturation
    do_reset();
    exp_fwd(32'habcd, 1, 0, 0); drive(32'habcd, 1, 0);
    exp_fwd(32'd1, 0, 0, 0);    drive(32'd1, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_fwd(32'habcd, 1, 1, 0);
      drive(32'habcd, 1, 1);
    end
    chk("sat_pkt_cnt", 32'(bus.pkt_cnt), 3);
    chk("sat_mis_cnt", 32'(bus.misroute_cnt), 0);
    chk("sat_err_cnt", 32'(bus.err_cnt), 0);
    drain("sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_egress_mon.md
# eth_egress_mon

Egress-port monitor and retimer placed directly downstream of one output port of the two-port Ethernet switch. It consumes the switch's 32-bit sop/eop word stream and checks packet framing. It forwards well-formed words to the port with one cycle of latency. It also keeps saturating statistics: good packets, misrouted packets and framing errors, plus the length and checksum of the last good packet. Two instances are used, one per switch output, each with that port's address.

## Interface
- PORT_ADDR, 'habcd: address owned by this port; a sop word that differs from it marks the packet as misrouted.
- MAX_WORDS, 64: maximum legal packet length in words, counting the sop word; must be ≥ 2.
- CNT_WIDTH, 16: width of each statistics counter.

- clk  in  1  Single clock; everything is sampled on the rising edge.
- rst  in  1  Synchronous reset, active-low.
- in_data  in  32  Word from the switch output.
- in_sop  in  1  First word of a packet. This word carries the destination address.
- in_eop  in  1  Last word of a packet.
- out_data  out  32  Forwarded word.
- out_valid  out  1  out_data holds a forwarded word.
- out_sop / out_eop  out  1  Framing of the forwarded word.
- out_abort  out  1  One-cycle pulse: the packet in progress on the output was truncated.
- err_flag  out  1  One-cycle pulse: a framing error was detected.
- err_code  out  2  1 = sop inside packet, 2 = orphan eop, 3 = oversize. Held until the next error.
- pkt_cnt  out  CNT_WIDTH  Good packets.
- misroute_cnt  out  CNT_WIDTH  Good packets whose sop word ≠ PORT_ADDR.
- err_cnt  out  CNT_WIDTH  Framing errors.
- last_len  out  16  Word count of the last good packet.
- last_csum  out  32  Modulo-2^32 sum of all words of the last good packet.

## Operation
- States: IDLE, BODY, DROP. Working registers:
  - len (16 bit)
  - csum (32 bit)
  - mis (1 bit)
- In BODY, every cycle is a packet word; the stream has no idle gaps inside a packet. In IDLE, cycles without sop or eop are idle bus cycles and are ignored.
- IDLE transitions:
  - sop with eop: single-word good packet. Forward it, update statistics, stay in IDLE.
  - sop alone: forward the word. Set len=1, csum=in_data, mis=(in_data≠PORT_ADDR). Go to BODY.
  - eop without sop: orphan, error code 2. Drop the word, stay in IDLE.
- BODY transitions, in priority order:
  - sop: error code 1. Pulse out_abort on the forwarded sop word. Restart len, csum and mis from this word. Stay in BODY; if eop is also set, complete it as a single-word good packet and go to IDLE.
  - len == MAX_WORDS: oversize, error code 3. Drop the word and pulse out_abort with out_valid=0. If eop is set go to IDLE, otherwise go to DROP.
  - eop: forward the word. The packet is good with final len = len+1 and csum = csum+in_data. Go to IDLE.
  - otherwise: forward the word. Increment len, add the word to csum.
- DROP: discard all words. eop goes to IDLE. sop counts as error code 1 and is handled exactly as sop in IDLE.
- On a good packet:
  - increment pkt_cnt;
  - also increment misroute_cnt if mis is set;
  - load last_len and last_csum with the final values.
- Every error increments err_cnt.
- All counters saturate at all-ones.
- A packet of exactly MAX_WORDS words is legal.

## Timing
- All outputs are registered. out_data, out_valid, out_sop, out_eop, out_abort, err_flag and err_code are valid one cycle after the input word that causes them.
- The counters, last_len and last_csum update in the same cycle as out_eop for that packet.
- Reset (rst=0 at an edge) forces the following; it takes effect mid-packet, and the truncated packet is not counted:
  - state = IDLE;
  - all outputs = 0, including out_data and err_code;
  - len, csum and mis = 0.
- The first word accepted after reset is sampled on the first edge with rst=1.
- When no word is forwarded, out_valid, out_sop and out_eop are 0 and out_data holds its last value.

## Test plan
- PORT_ADDR='habcd. Send a 4-word packet 'habcd, 1, 2, 3 with sop on word 0 and eop on word 3. Required: 4 forwarded words, each 1 cycle late; pkt_cnt=1, last_len=4, last_csum='habd3, misroute_cnt=0.
- Send a single word 'hcdef with sop and eop together. Required: one forwarded word with out_sop=out_eop=1; pkt_cnt=1, misroute_cnt=1, last_len=1.
- Start a packet (sop, then 2 words), then send sop 'habcd, 5 with eop. Required:
  - err_code=1, err_cnt=1, out_abort pulses on the new sop;
  - pkt_cnt=1, last_len=2, last_csum='habd2.
- MAX_WORDS=4. Send 6 words with eop on word 6. Required:
  - words 1–4 forwarded; out_abort and err_code=3 one cycle after word 5;
  - word 6 is dropped, pkt_cnt=0, err_cnt=1.
- Pulse eop alone while in IDLE. Required: err_code=2, err_cnt=1, out_valid stays 0.
- CNT_WIDTH=2. Drive rst low after word 2 of a packet, then send 5 good packets. Required:
  - all outputs 0 after reset; the truncated packet is not counted;
  - pkt_cnt saturates at 3.
